// File: rtl/nn_pkg.sv
// Shared types for the flatten_stream slice: FSM state encoding, order-mode codes
// and a width helper that never returns zero for degenerate (size-1) dimensions.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } flat_state_t;

    localparam logic ORDER_CHW = 1'b0;
    localparam logic ORDER_HWC = 1'b1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flatten_stream_if.sv
// Memory read port and output pixel stream of flatten_stream, bundled as one interface.
// master = the flattener, slave = the feature-map memory plus the downstream consumer.
interface flatten_stream_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pixel_out;
    logic              pixel_valid;
    logic              pixel_ready;
    logic              pixel_last;

    modport master (
        output mem_rd_en, mem_addr, pixel_out, pixel_valid, pixel_last,
        input  mem_rdata, pixel_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, pixel_out, pixel_valid, pixel_last,
        output mem_rdata, pixel_ready
    );
endinterface

// File: rtl/flatten_skid.sv
// Two-entry valid/ready buffer carrying pixel word + last flag, with occupancy output.
// Define FLATTEN_RELU_EN to clamp negative words to zero on the read side.
module flatten_skid #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        occ
);
    logic [DATA_W:0] ent0_q, ent0_d;
    logic [DATA_W:0] ent1_q, ent1_d;
    logic [1:0]      occ_q, occ_d;
    logic            pop;

    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid & out_ready;

    // Writer never pushes into a full buffer: the read issuer holds a credit for every slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({in_valid, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = {in_last, in_data};
                else               ent1_d = {in_last, in_data};
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = {in_last, in_data};
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = {in_last, in_data};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ      = occ_q;
    assign out_last = out_valid & ent0_q[DATA_W];

`ifdef FLATTEN_RELU_EN
    assign out_data = ent0_q[DATA_W-1] ? '0 : ent0_q[DATA_W-1:0];
`else
    assign out_data = ent0_q[DATA_W-1:0];
`endif

endmodule

// File: rtl/flatten_stream.sv
// Reads an HxWxC CHW-laid-out feature map and streams it out in CHW or HWC order.
// Optional FLATTEN_RELU_EN (applied inside flatten_skid) zeroes negative words.
//
//   state | meaning
//   IDLE  | waiting for start; the accepting cycle already issues the first read
//   RUN   | issuing reads as buffer credit allows
//   DRAIN | all addresses issued, waiting for the last beat handshake
//   DONE  | one-cycle done pulse, then back to IDLE
module flatten_stream
    import nn_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int HEIGHT   = 28,
    parameter int WIDTH    = 28,
    parameter int CHANNELS = 1,
    parameter int ADDR_W   = cnt_w(HEIGHT * WIDTH * CHANNELS)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic order_mode,
    output logic busy,
    output logic done,
    flatten_stream_if.master bus
);
    localparam int COL_W = cnt_w(WIDTH);
    localparam int ROW_W = cnt_w(HEIGHT);
    localparam int CH_W  = cnt_w(CHANNELS);
    localparam int PLANE = HEIGHT * WIDTH;
    localparam logic [ADDR_W-1:0] PLANE_STEP = ADDR_W'(PLANE);
    localparam logic [ADDR_W-1:0] CH_REWIND  = ADDR_W'((CHANNELS - 1) * PLANE);

    flat_state_t       state_q, state_d;
    logic              mode_q, mode_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;

    logic              issue, mode_sel, pop, credit_ok;
    logic              col_max, row_max, ch_max, at_last;
    logic [1:0]        occ;
    logic [2:0]        load;
    logic              sk_valid, sk_last;
    logic [DATA_W-1:0] sk_data;

    assign col_max  = (col_q == COL_W'(WIDTH - 1));
    assign row_max  = (row_q == ROW_W'(HEIGHT - 1));
    assign ch_max   = (ch_q == CH_W'(CHANNELS - 1));
    assign at_last  = col_max & row_max & ch_max;
    assign mode_sel = (state_q == IDLE) ? order_mode : mode_q;

    // The beat leaving this cycle frees its slot now, which keeps one beat per cycle.
    assign pop       = sk_valid & bus.pixel_ready;
    assign load      = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    assign credit_ok = (load < 3'd2);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && credit_ok) begin
                    issue   = 1'b1;
                    mode_d  = order_mode;
                    state_d = at_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (at_last) state_d = DRAIN;
                end
            end
            DRAIN: if (pop && sk_last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!reset) issue = 1'b0;

        if (issue) begin
            if (at_last) begin
                col_d  = '0;
                row_d  = '0;
                ch_d   = '0;
                addr_d = '0;
            end else if (mode_sel == ORDER_CHW) begin
                addr_d = addr_q + ADDR_W'(1);
                col_d  = col_max ? '0 : col_q + COL_W'(1);
                if (col_max) begin
                    row_d = row_max ? '0 : row_q + ROW_W'(1);
                    if (row_max) ch_d = ch_q + CH_W'(1);
                end
            end else begin
                ch_d = ch_max ? '0 : ch_q + CH_W'(1);
                // Channel wrap rewinds to plane 0 and steps one pixel; row carry needs no extra term.
                if (ch_max) begin
                    addr_d = addr_q + ADDR_W'(1) - CH_REWIND;
                    col_d  = col_max ? '0 : col_q + COL_W'(1);
                    if (col_max) row_d = row_q + ROW_W'(1);
                end else begin
                    addr_d = addr_q + PLANE_STEP;
                end
            end
        end

        infl_d      = issue;
        infl_last_d = issue & at_last;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= ORDER_CHW;
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            addr_q      <= addr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    flatten_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (infl_q),
        .in_data   (bus.mem_rdata),
        .in_last   (infl_last_q),
        .out_valid (sk_valid),
        .out_ready (bus.pixel_ready),
        .out_data  (sk_data),
        .out_last  (sk_last),
        .occ       (occ)
    );

    assign bus.mem_rd_en   = issue;
    assign bus.mem_addr    = addr_q;
    assign bus.pixel_out   = sk_data;
    assign bus.pixel_valid = sk_valid;
    assign bus.pixel_last  = sk_last;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_flatten_stream.sv
// Directed bench for flatten_stream: default 28x28x1, a 2x2x2 instance and a 1x1x1 instance.
module tb_flatten_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_b, mode_b, busy_b, done_b;
    logic start_s, mode_s, busy_s, done_s;
    logic start_o, mode_o, busy_o, done_o;

    flatten_stream_if #(.DATA_W(16), .ADDR_W(10)) bus_b ();
    flatten_stream_if #(.DATA_W(16), .ADDR_W(3))  bus_s ();
    flatten_stream_if #(.DATA_W(16), .ADDR_W(1))  bus_o ();

    flatten_stream #(.DATA_W(16)) u_big (
        .clk(clk), .reset(reset), .start(start_b), .order_mode(mode_b),
        .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    flatten_stream #(.DATA_W(16), .HEIGHT(2), .WIDTH(2), .CHANNELS(2)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .order_mode(mode_s),
        .busy(busy_s), .done(done_s), .bus(bus_s)
    );

    flatten_stream #(.DATA_W(16), .HEIGHT(1), .WIDTH(1), .CHANNELS(1)) u_one (
        .clk(clk), .reset(reset), .start(start_o), .order_mode(mode_o),
        .busy(busy_o), .done(done_o), .bus(bus_o)
    );

    logic [15:0] mem_s [8];
    always @(posedge clk) begin
        if (bus_b.mem_rd_en) bus_b.mem_rdata <= 16'(bus_b.mem_addr);
        if (bus_s.mem_rd_en) bus_s.mem_rdata <= mem_s[bus_s.mem_addr];
        if (bus_o.mem_rd_en) bus_o.mem_rdata <= 16'h1234;
    end

    bit rand_en = 1'b0;
    always @(posedge clk) begin
        #1;
        bus_b.pixel_ready = (rand_en && ($urandom_range(0, 3) == 0)) ? 1'b0 : 1'b1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor for the default-size instance.
    int          frame_id = 0;
    int          mon_frame = 0;
    int          exp_idx, beat_cnt, first_cyc, last_cyc, bubbles, stalls;
    bit          seen_first, prev_stall;
    logic [15:0] prev_out;

    always @(negedge clk) begin
        if (mon_frame != frame_id) begin
            mon_frame  = frame_id;
            exp_idx    = 0;
            beat_cnt   = 0;
            bubbles    = 0;
            stalls     = 0;
            seen_first = 1'b0;
            prev_stall = 1'b0;
        end else if (reset) begin
            if (prev_stall) check("stall_hold", 32'(bus_b.pixel_out), 32'(prev_out));
            if (bus_b.pixel_valid && bus_b.pixel_ready) begin
                check("beat_val", 32'(bus_b.pixel_out), 32'(exp_idx));
                check("beat_last", 32'(bus_b.pixel_last), 32'(exp_idx == 783));
                if (!seen_first) first_cyc = cyc;
                seen_first = 1'b1;
                last_cyc   = cyc;
                exp_idx++;
                beat_cnt++;
            end else if (seen_first && exp_idx < 784) begin
                if (bus_b.pixel_valid) stalls++;
                else                   bubbles++;
            end
            prev_stall = bus_b.pixel_valid && !bus_b.pixel_ready;
            prev_out   = bus_b.pixel_out;
        end
    end

    task automatic check_big_zero(input string tag);
        check({tag, "_out"},   32'(bus_b.pixel_out),   32'd0);
        check({tag, "_valid"}, 32'(bus_b.pixel_valid), 32'd0);
        check({tag, "_last"},  32'(bus_b.pixel_last),  32'd0);
        check({tag, "_done"},  32'(done_b),            32'd0);
        check({tag, "_busy"},  32'(busy_b),            32'd0);
        check({tag, "_rden"},  32'(bus_b.mem_rd_en),   32'd0);
        check({tag, "_addr"},  32'(bus_b.mem_addr),    32'd0);
    endtask

    task automatic wait_big_done(input string tag);
        int n = 0;
        while (!done_b && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_b), 32'd1);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beat_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_beats", 32'(beat_cnt >= target), 32'd1);
    endtask

    logic [15:0] sv [16];
    logic        sl [16];
    int          sn;

    task automatic run_small(input logic mode);
        int t = 0;
        sn = 0;
        start_s = 1'b1;
        mode_s  = mode;
        @(negedge clk);
        start_s = 1'b0;
        while (!done_s && t < 200) begin
            if (bus_s.pixel_valid && bus_s.pixel_ready && sn < 16) begin
                sv[sn] = bus_s.pixel_out;
                sl[sn] = bus_s.pixel_last;
                sn++;
            end
            @(negedge clk);
            t++;
        end
        check("small_done", 32'(done_s), 32'd1);
        @(negedge clk);
    endtask

    logic [15:0] exp_hwc [8] = '{16'd0, 16'd4, 16'd1, 16'd5, 16'd2, 16'd6, 16'd3, 16'd7};
    logic [15:0] exp_relu0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        start_b = 1'b0; mode_b = 1'b0;
        start_s = 1'b0; mode_s = 1'b0;
        start_o = 1'b0; mode_o = 1'b0;
        bus_s.pixel_ready = 1'b1;
        bus_o.pixel_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem_s[i] = 16'(i);

        repeat (3) @(negedge clk);
        check_big_zero("rst");

        // Frame 1: ready held high, mode 0
        reset = 1'b1;
        frame_id++;
        @(negedge clk);
        start_b = 1'b1;
        mode_b  = 1'b0;
        #1;
        check("rden_at_start", 32'(bus_b.mem_rd_en), 32'd1);
        check("addr_at_start", 32'(bus_b.mem_addr),  32'd0);
        @(negedge clk);
        start_b = 1'b0;
        check("busy_run",   32'(busy_b),            32'd1);
        check("valid_lat0", 32'(bus_b.pixel_valid), 32'd0);
        @(negedge clk);
        check("valid_lat1", 32'(bus_b.pixel_valid), 32'd1);
        wait_big_done("done1");
        check("beats1",    32'(beat_cnt),            32'd784);
        check("span1",     32'(last_cyc - first_cyc), 32'd783);
        check("done_lat1", 32'(cyc - last_cyc),      32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done_b), 32'd0);
        check("busy_idle",  32'(busy_b), 32'd0);

        // Frame 2: random ready, order_mode flipped after acceptance
        frame_id++;
        @(negedge clk);
        rand_en = 1'b1;
        start_b = 1'b1;
        mode_b  = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        mode_b  = 1'b1;
        wait_big_done("done2");
        rand_en = 1'b0;
        check("beats2",   32'(beat_cnt), 32'd784);
        check("bubbles2", 32'(bubbles),  32'd0);
        check("span2",    32'(last_cyc - first_cyc), 32'(783 + stalls));
        mode_b = 1'b0;
        @(negedge clk);

        // Frame 3: reset at beat 100, restart, stray starts mid-frame and in DONE
        frame_id++;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_beats(100);
        reset = 1'b0;
        @(negedge clk);
        check_big_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        frame_id++;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_beats(300);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_big_done("done3");
        start_b = 1'b1;
        check("beats3", 32'(beat_cnt), 32'd784);
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        check("busy_after_done_start", 32'(busy_b), 32'd0);

        // 2x2x2 instance: HWC then CHW order
        run_small(1'b1);
        check("hwc_count", 32'(sn), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("hwc_val",  32'(sv[i]), 32'(exp_hwc[i]));
            check("hwc_last", 32'(sl[i]), 32'(i == 7));
        end
        run_small(1'b0);
        check("chw_count", 32'(sn), 32'd8);
        for (int i = 0; i < 8; i++) check("chw_val", 32'(sv[i]), 32'(i));

        mem_s[0] = 16'hFFF0;
        mem_s[1] = 16'h0010;
`ifdef FLATTEN_RELU_EN
        exp_relu0 = 16'h0000;
`else
        exp_relu0 = 16'hFFF0;
`endif
        run_small(1'b0);
        check("relu_word0", 32'(sv[0]), 32'(exp_relu0));
        check("relu_word1", 32'(sv[1]), 32'h0010);

        // 1x1x1 instance: valid and last together on the only beat
        start_o = 1'b1;
        @(negedge clk);
        start_o = 1'b0;
        check("one_valid0", 32'(bus_o.pixel_valid), 32'd0);
        @(negedge clk);
        check("one_valid1", 32'(bus_o.pixel_valid), 32'd1);
        check("one_last",   32'(bus_o.pixel_last),  32'd1);
        check("one_data",   32'(bus_o.pixel_out),   32'h1234);
        @(negedge clk);
        check("one_done",   32'(done_o), 32'd1);
        @(negedge clk);
        check("one_idle",   32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flatten_stream.md
# flatten_stream

Parametrised successor to the fixed-size flatten block. It reads an H×W×C feature map of signed fixed-point words from a synchronous-read memory and emits it as a 1-D pixel stream with valid/ready backpressure and an end-of-frame marker. Output order is selectable between channel-major and channel-interleaved. It sits between the feature-map buffer of the last conv/pool stage and the first dense layer of the MNIST network.

## Interface
- DATA_W, 16, pixel word width (signed fixed-point, passed through unchanged)
- HEIGHT, 28, rows per channel plane
- WIDTH, 28, columns per row
- CHANNELS, 1, number of planes
- ADDR_W, $clog2(HEIGHT*WIDTH*CHANNELS), memory address width (derived)
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  begin one frame; sampled only in IDLE
- order_mode  input  1  0 = channel-major (CHW), 1 = interleaved (HWC); latched at accepted start
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  read address; memory layout is CHW, addr = c·H·W + r·W + col
- mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en
- pixel_out  output  DATA_W  stream data
- pixel_valid  output  1  stream valid
- pixel_ready  input  1  downstream ready
- pixel_last  output  1  high with the final pixel of the frame
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE → RUN on start; RUN → DRAIN when the last address has been issued; DRAIN → DONE when the last beat completes its handshake; DONE → IDLE unconditionally. DONE lasts one cycle and drives done=1.
- Counters: col, row, and ch, with wrap-around carry. In mode 0 the nesting is ch(outer)/row/col(inner). In mode 1 it is row/col/ch(inner).
- Address for the current counters is c·H·W + r·W + col, computed with counter increments (no multiplier in the datapath).
- Reads are credit-controlled by a 2-entry output buffer: issue only while (occupancy + reads in flight) < 2. No read data is ever dropped.
- A beat completes when pixel_valid & pixel_ready. pixel_out and pixel_last hold stable while pixel_valid=1 and pixel_ready=0.
- Exactly H·W·C beats per frame.
- start is ignored outside IDLE. A start pulse arriving in the DONE cycle is also ignored.
- order_mode changes mid-frame have no effect.
- Reset (reset=0) at any time: FSM returns to IDLE, counters are cleared, the buffer is flushed, and in-flight read data is discarded.
- Reset value of every output is 0: pixel_out, pixel_valid, pixel_last, done, busy, mem_rd_en, mem_addr.

## Timing
- start sampled at edge k → mem_rd_en=1, mem_addr=first address during cycle k.
- Data is captured at edge k+1, so pixel_valid=1 from edge k+1. Latency is 1 cycle after the accepting edge, 2 edges from the start assertion edge.
- With pixel_ready held at 1: one beat per cycle, frame spans H·W·C consecutive cycles, and done pulses the cycle after the pixel_last handshake.
- A ready deassertion for N cycles stalls the output for exactly N cycles. Throughput recovers to 1 beat/cycle with no bubble.
- Single-pixel frame (H=W=C=1): pixel_valid and pixel_last are asserted together on the first beat.

## Configuration
- FLATTEN_RELU_EN defined: pixel_out = 0 when the buffered word is negative (MSB=1), otherwise unchanged. The clamp is applied at the buffer output and adds no latency.
- FLATTEN_RELU_EN undefined: words pass through bit-exact.

## Structure
- Shared package nn_pkg: the FSM state enum (IDLE, RUN, DRAIN, DONE) and the order-mode constants ORDER_CHW=0 and ORDER_HWC=1.
- One sub-module, flatten_skid: a 2-entry valid/ready buffer with occupancy output. It is used for the credit check and for the ReLU clamp on its read side.
- The top level holds the FSM, counters, address generation and the in-flight flag.

## Test plan
- Default params, memory word = address, ready=1, mode 0, start one pulse → 784 beats with values 0..783 in order; pixel_last on value 783; done one cycle later; busy low after DONE.
- H=W=C=2, mode 1, identity memory → sequence 0,4,1,5,2,6,3,7; pixel_last on 7. The same configuration in mode 0 → 0..7.
- Default params, ready toggling in a random pattern → values still 0..783, no duplicates or drops; pixel_out stable during every stall.
- Reset asserted at beat 100, then start reissued → all outputs 0 during reset, and the new frame begins at value 0.
- start pulsed mid-frame and in the DONE cycle → ignored; beat count stays 784.
- With FLATTEN_RELU_EN, memory word 0xFFF0 at address 0 and 0x0010 at address 1 → pixel_out 0x0000 then 0x0010. Without the macro → 0xFFF0 then 0x0010.
